// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU control path: opcodes, ALU/ACC-source/fault codes, FSM states.
package cpu_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_LDA  = 4'h4;
  localparam logic [3:0] OP_STA  = 4'h5;
  localparam logic [3:0] OP_ADD  = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_JZ   = 4'hB;
  localparam logic [3:0] OP_JC   = 4'hC;
  localparam logic [3:0] OP_OUT  = 4'hD;
  localparam logic [3:0] OP_ILL  = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'b000;
  localparam logic [2:0] ALU_SUB    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_OR     = 3'b011;
  localparam logic [2:0] ALU_PASS_B = 3'b100;

  localparam logic [1:0] ACC_SRC_IMM = 2'b00;
  localparam logic [1:0] ACC_SRC_ALU = 2'b01;
  localparam logic [1:0] ACC_SRC_MEM = 2'b10;

  localparam logic [1:0] FAULT_NONE    = 2'b00;
  localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
  localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_LOAD_IR,
    ST_DECODE,
    ST_MEM_RD,
    ST_MEM_WR,
    ST_HALT
  } state_t;

  function automatic logic [2:0] alu_for_op(input logic [3:0] op);
    case (op)
      OP_SUB, OP_SUBI: alu_for_op = ALU_SUB;
      OP_AND:          alu_for_op = ALU_AND;
      OP_OR:           alu_for_op = ALU_OR;
      default:         alu_for_op = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_watchdog.sv
// Memory wait-state watchdog: saturating 8-bit count of stalled cycles, cleared on FSM state change.
// Timeout is combinational and only fires while still stalled, so a same-cycle mem_ready wins.
module ctrl_watchdog #(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic i_active,
  input  logic i_mem_ready,
  input  logic i_clear,
  output logic o_timeout
);

  localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

  logic [7:0] r_wait_cnt;
  logic       w_waiting;

  assign w_waiting = i_active & ~i_mem_ready;
  assign o_timeout = w_waiting && (r_wait_cnt == LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 8'd0;
    end else if (i_clear) begin
      r_wait_cnt <= 8'd0;
    end else if (w_waiting && (r_wait_cnt != 8'hFF)) begin
      r_wait_cnt <= r_wait_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/cpu_controller.sv
// Multi-cycle fetch/decode/execute control FSM for the 8-bit accumulator CPU.
// 3 cycles per register op, 4 per memory op, +1 per wait state; stalls past WAIT_LIMIT halt with a bus fault.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       zero_flag,
  input  logic       carry_flag,
  input  logic       mem_ready,
  output logic       load_ir,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       addr_sel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       acc_load,
  output logic [1:0] acc_src,
  output logic [2:0] alu_op,
  output logic       alu_b_sel,
  output logic       flags_load,
  output logic       out_load,
  output logic       halted,
  output logic [1:0] fault
);

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_fault;
  logic       w_active;
  logic       w_timeout;

  assign w_active = (r_state == ST_FETCH) || (r_state == ST_MEM_RD) || (r_state == ST_MEM_WR);

  ctrl_watchdog #(.WAIT_LIMIT(WAIT_LIMIT)) u_watchdog (
    .clk         (clk),
    .reset       (reset),
    .i_active    (w_active),
    .i_mem_ready (mem_ready),
    .i_clear     (w_next != r_state),
    .o_timeout   (w_timeout)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_FETCH;
      r_fault <= FAULT_NONE;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE && opcode == OP_ILL) begin
        r_fault <= FAULT_ILLEGAL;
      end else if (w_timeout) begin
        r_fault <= FAULT_TIMEOUT;
      end
    end
  end

  // Every output is forced low while reset is high, independent of the registered state.
  always_comb begin
    w_next     = r_state;
    load_ir    = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    addr_sel   = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    acc_load   = 1'b0;
    acc_src    = ACC_SRC_IMM;
    alu_op     = ALU_ADD;
    alu_b_sel  = 1'b0;
    flags_load = 1'b0;
    out_load   = 1'b0;
    halted     = 1'b0;
    fault      = FAULT_NONE;
    if (!reset) begin
      fault = r_fault;
      case (r_state)
        ST_FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready)      w_next = ST_LOAD_IR;
          else if (w_timeout) w_next = ST_HALT;
        end
        ST_LOAD_IR: begin
          load_ir = 1'b1;
          pc_inc  = 1'b1;
          w_next  = ST_DECODE;
        end
        ST_DECODE: begin
          w_next = ST_FETCH;
          case (opcode)
            OP_LDI: begin
              acc_load = 1'b1;
              acc_src  = ACC_SRC_IMM;
            end
            OP_ADDI, OP_SUBI: begin
              acc_load   = 1'b1;
              acc_src    = ACC_SRC_ALU;
              alu_op     = alu_for_op(opcode);
              flags_load = 1'b1;
            end
            OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR: w_next = ST_MEM_RD;
            OP_STA:         w_next   = ST_MEM_WR;
            OP_JMP:         pc_load  = 1'b1;
            OP_JZ:          pc_load  = zero_flag;
            OP_JC:          pc_load  = carry_flag;
            OP_OUT:         out_load = 1'b1;
            OP_ILL, OP_HLT: w_next   = ST_HALT;
            default: ;
          endcase
        end
        ST_MEM_RD: begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready) begin
            w_next   = ST_FETCH;
            acc_load = 1'b1;
            if (opcode == OP_LDA) begin
              acc_src = ACC_SRC_MEM;
            end else begin
              acc_src    = ACC_SRC_ALU;
              alu_op     = alu_for_op(opcode);
              alu_b_sel  = 1'b1;
              flags_load = 1'b1;
            end
          end else if (w_timeout) begin
            w_next = ST_HALT;
          end
        end
        ST_MEM_WR: begin
          mem_wr   = 1'b1;
          addr_sel = 1'b1;
          if (mem_ready)      w_next = ST_FETCH;
          else if (w_timeout) w_next = ST_HALT;
        end
        ST_HALT: halted = 1'b1;
        default: w_next = ST_FETCH;
      endcase
    end
  end

endmodule
